// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule slice.
// Holds the field widths, the round-constant seed, the GF(2^8) reduction
// constant, the key-expansion FSM state type and the xtime helper.
package aes_pkg;

    localparam int BYTE       = 8;
    localparam int WORD       = 32;
    localparam int KEY_WIDTH  = 128;
    localparam int NUM_ROUNDS = 10;

    // Index of the last schedule word (w43 for AES-128).
    localparam int LAST_WORD = 4 * (NUM_ROUNDS + 1) - 1;

    localparam logic [BYTE-1:0] RCON_INIT  = 8'h01;
    localparam logic [BYTE-1:0] XTIME_POLY = 8'h1b;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/key_word_step.sv
// One key-schedule word step (combinational).
// new = w[i-4] ^ temp, where temp is w[i-1] or, on the first word of each
// round key, SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}.
// Ports:
//   w_first  - w[i-4], oldest window word
//   w_last   - w[i-1], newest window word
//   rcon     - current round constant
//   phase    - i[1:0]; 0 selects the rotate/substitute path
//   new_word - w[i]
module key_word_step
    import aes_pkg::*;
(
    input  logic [WORD-1:0] w_first,
    input  logic [WORD-1:0] w_last,
    input  logic [BYTE-1:0] rcon,
    input  logic [1:0]      phase,
    output logic [WORD-1:0] new_word
);

    logic [WORD-1:0] rotated;
    logic [WORD-1:0] substituted;
    logic [WORD-1:0] temp;

    rot_word u_rot_word (
        .word_in  (w_last),
        .word_out (rotated)
    );

    sub_word u_sub_word (
        .word_in  (rotated),
        .word_out (substituted)
    );

    assign temp     = (phase == 2'd0) ? (substituted ^ {rcon, 24'h0}) : w_last;
    assign new_word = w_first ^ temp;

endmodule

// File: rtl/rot_word.sv
// RotWord: cyclic left rotation of a word by one byte.
// Ports:
//   word_in  - input word {a0,a1,a2,a3}
//   word_out - rotated word {a1,a2,a3,a0}
module rot_word
    import aes_pkg::*;
(
    input  logic [WORD-1:0] word_in,
    output logic [WORD-1:0] word_out
);

    assign word_out = {word_in[WORD-BYTE-1:0], word_in[WORD-1 -: BYTE]};

endmodule

// File: rtl/sub_word.sv
// SubWord: applies the AES S-box to each byte of a word.
// The S-box is computed as multiplicative inverse followed by the affine
// transform, so no 256-entry table has to be maintained by hand.
// Ports:
//   word_in  - input word
//   word_out - byte-wise substituted word
module sub_word
    import aes_pkg::*;
(
    input  logic [WORD-1:0] word_in,
    output logic [WORD-1:0] word_out
);

    function automatic logic [BYTE-1:0] gf_mul(input logic [BYTE-1:0] a,
                                               input logic [BYTE-1:0] b);
        logic [BYTE-1:0] acc;
        logic [BYTE-1:0] aa;
        acc = '0;
        aa  = a;
        for (int k = 0; k < BYTE; k++) begin
            if (b[k]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // a^254 = a^(2+4+...+128); maps 0 to 0 as the S-box requires.
    function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] a);
        logic [BYTE-1:0] sq;
        logic [BYTE-1:0] inv;
        logic [BYTE-1:0] rot;
        logic [BYTE-1:0] res;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < BYTE; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        rot = inv;
        res = inv;
        for (int k = 0; k < 4; k++) begin
            rot = {rot[6:0], rot[7]};
            res = res ^ rot;
        end
        return res ^ 8'h63;
    endfunction

    always_comb begin
        word_out = '0;
        for (int b = 0; b < WORD / BYTE; b++) begin
            word_out[b*BYTE +: BYTE] = sbox(word_in[b*BYTE +: BYTE]);
        end
    end

endmodule

// File: rtl/key_expansion_controller.sv
// Sequential AES-128 key-schedule engine: one 32-bit word per clock.
// A start accepted in IDLE loads the cipher key and immediately strobes it
// out as round key 0; the next 40 cycles generate w4..w43 and strobe each
// completed round key. done marks the round-10 strobe.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   start           - begin expansion (only looked at in IDLE)
//   cipher_key      - key, captured on the accepted start edge
//   busy            - high while w4..w43 are being produced
//   round_key_valid - one-cycle strobe, round_key/round_key_index updated
//   round_key_index - round number of round_key
//   round_key       - {w[4k], w[4k+1], w[4k+2], w[4k+3]}, held between strobes
//   done            - one-cycle pulse with the index-10 strobe
module key_expansion_controller
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KEY_WIDTH-1:0] cipher_key,
    output logic                 busy,
    output logic                 round_key_valid,
    output logic [3:0]           round_key_index,
    output logic [KEY_WIDTH-1:0] round_key,
    output logic                 done
);

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            last_step;

    // win[0] = w[i-4] ... win[3] = w[i-1]
    logic [WORD-1:0] win [4];
    logic [5:0]      word_idx;
    logic [BYTE-1:0] rcon;
    logic [WORD-1:0] new_word;

    key_word_step u_key_word_step (
        .w_first  (win[0]),
        .w_last   (win[3]),
        .rcon     (rcon),
        .phase    (word_idx[1:0]),
        .new_word (new_word)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                if (word_idx == 6'(LAST_WORD)) begin
                    last_step  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) win[k] <= '0;
            word_idx        <= '0;
            rcon            <= '0;
            busy            <= 1'b0;
            round_key_valid <= 1'b0;
            round_key_index <= '0;
            round_key       <= '0;
            done            <= 1'b0;
        end else begin
            round_key_valid <= 1'b0;
            done            <= 1'b0;
            if (accept) begin
                for (int k = 0; k < 4; k++) begin
                    win[k] <= cipher_key[KEY_WIDTH-1-WORD*k -: WORD];
                end
                word_idx        <= 6'd4;
                rcon            <= RCON_INIT;
                busy            <= 1'b1;
                round_key       <= cipher_key;
                round_key_index <= '0;
                round_key_valid <= 1'b1;
            end else if (state == EXPAND) begin
                win[0]   <= win[1];
                win[1]   <= win[2];
                win[2]   <= win[3];
                win[3]   <= new_word;
                word_idx <= word_idx + 6'd1;
                if (word_idx[1:0] == 2'd0) rcon <= xtime(rcon);
                // Fourth word of a round key: the window plus the new word
                // is the complete key, numbered i/4.
                if (word_idx[1:0] == 2'd3) begin
                    round_key       <= {win[1], win[2], win[3], new_word};
                    round_key_index <= word_idx[5:2];
                    round_key_valid <= 1'b1;
                end
                if (last_step) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_expansion_controller.sv
module tb_key_expansion_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] cipher_key;
    logic         busy;
    logic         round_key_valid;
    logic [3:0]   round_key_index;
    logic [127:0] round_key;
    logic         done;

    key_expansion_controller dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cipher_key      (cipher_key),
        .busy            (busy),
        .round_key_valid (round_key_valid),
        .round_key_index (round_key_index),
        .round_key       (round_key),
        .done            (done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]   sbox_tab [256];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] exp_q [$];
    logic [127:0] obs_rk [11];

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // S-box table from the generator walk: p steps through all non-zero
    // field elements by *3, q tracks its inverse by /3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tab[0] = 8'h63;
    endtask

    // Full AES-128 key schedule; pushes the 11 round keys in order.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rcon_tab[i/4-1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) exp_q.push_back({w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]});
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // ---------------- driver / scoreboard ----------------
    // Entered at a negedge with start=1 and cipher_key=key already driven.
    // Walks the 41 cycles after the accepting edge and checks every output.
    // glitch_at: edge number at which start is re-pulsed with another key.
    // hold_start: leave start high, with next_key applied for the next edge.
    task automatic run_expansion(input logic [127:0] key, input int glitch_at,
                                 input bit hold_start, input logic [127:0] next_key);
        logic [127:0] held;
        logic [127:0] exp_rk;
        held = '0;
        model_expand(key);
        for (int n = 0; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 40) begin
                start      = hold_start;
                cipher_key = hold_start ? next_key : rand_key();
            end else begin
                start      = hold_start || (n + 1 == glitch_at);
                cipher_key = (n + 1 == glitch_at) ? ~key : rand_key();
            end
            check("valid", 128'(round_key_valid), 128'(n % 4 == 0));
            check("busy",  128'(busy),            128'(n < 40));
            check("done",  128'(done),            128'(n == 40));
            if (n % 4 == 0) begin
                check("index", 128'(round_key_index), 128'(n / 4));
                if (exp_q.size() == 0) begin
                    check("exp_q_underflow", 128'(1), 128'(0));
                end else begin
                    exp_rk = exp_q.pop_front();
                    check("round_key", round_key, exp_rk);
                    held = exp_rk;
                end
                obs_rk[n/4] = round_key;
            end else begin
                check("round_key_hold", round_key, held);
            end
        end
        check("exp_q_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic idle_cycles(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_valid", 128'(round_key_valid), 128'(0));
            check("idle_busy",  128'(busy),            128'(0));
            check("idle_done",  128'(done),            128'(0));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int strobes;
        build_sbox();
        reset      = 1'b1;
        start      = 1'b0;
        cipher_key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 128'(round_key_valid), 128'(0));
        check("reset_busy",  128'(busy),            128'(0));
        check("reset_done",  128'(done),            128'(0));
        check("reset_index", 128'(round_key_index), 128'(0));
        check("reset_key",   round_key,             128'(0));
        reset = 1'b0;
        idle_cycles(2);

        // FIPS-197 example key
        @(negedge clk);
        start = 1'b1; cipher_key = FIPS_KEY;
        run_expansion(FIPS_KEY, 0, 1'b0, '0);
        check("fips_rk0",    obs_rk[0], FIPS_KEY);
        check("fips_rk1_w4", 128'(obs_rk[1][127:96]), 128'(32'ha0fafe17));
        check("fips_rk10",   obs_rk[10], FIPS_RK10);
        idle_cycles(5);

        // All-zero key
        @(negedge clk);
        start = 1'b1; cipher_key = '0;
        run_expansion('0, 0, 1'b0, '0);
        check("zero_rk1",  obs_rk[1],  ZERO_RK1);
        check("zero_rk10", obs_rk[10], ZERO_RK10);
        idle_cycles(3);

        // start re-pulsed with another key while busy
        @(negedge clk);
        start = 1'b1; cipher_key = FIPS_KEY;
        run_expansion(FIPS_KEY, 10, 1'b0, '0);
        check("glitch_rk10", obs_rk[10], FIPS_RK10);
        idle_cycles(3);

        // reset in the middle of an expansion
        @(negedge clk);
        start = 1'b1; cipher_key = rand_key();
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            start      = 1'b0;
            cipher_key = rand_key();
            if (n == 19) reset = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_valid", 128'(round_key_valid), 128'(0));
        check("abort_busy",  128'(busy),            128'(0));
        check("abort_done",  128'(done),            128'(0));
        check("abort_index", 128'(round_key_index), 128'(0));
        check("abort_key",   round_key,             128'(0));
        strobes = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (round_key_valid || done || busy) strobes++;
        end
        check("abort_no_activity", 128'(strobes), 128'(0));
        begin
            logic [127:0] k;
            k = rand_key();
            @(negedge clk);
            start = 1'b1; cipher_key = k;
            run_expansion(k, 0, 1'b0, '0);
        end
        idle_cycles(2);

        // back-to-back: start held high across the done cycle
        @(negedge clk);
        start = 1'b1; cipher_key = FIPS_KEY;
        run_expansion(FIPS_KEY, 0, 1'b1, '0);
        run_expansion('0, 0, 1'b0, '0);
        check("b2b_rk10", obs_rk[10], ZERO_RK10);
        idle_cycles(2);

        // random keys
        for (int r = 0; r < 4; r++) begin
            logic [127:0] k;
            k = rand_key();
            @(negedge clk);
            start = 1'b1; cipher_key = k;
            run_expansion(k, int'($urandom_range(0, 40)), 1'b0, '0);
            idle_cycles(int'($urandom_range(1, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
